// File: rtl/elevator_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : elevator_controller_if
// Brief    : Call/actuator bundle between the elevator controller and its
//            surroundings (call buttons in, motor/door/status out).
// Revision : 1.0 - initial release
// ============================================================================
interface elevator_controller_if;
    logic [3:0] call_req;
    logic [1:0] current_floor;
    logic       motor_up;
    logic       motor_down;
    logic       door_open;
    logic [3:0] pending;

    // Environment side: raises calls, observes the car.
    modport master (
        output call_req,
        input  current_floor,
        input  motor_up,
        input  motor_down,
        input  door_open,
        input  pending
    );

    // Controller side.
    modport slave (
        input  call_req,
        output current_floor,
        output motor_up,
        output motor_down,
        output door_open,
        output pending
    );
endinterface
`default_nettype wire

// File: rtl/elevator_controller.sv
`default_nettype none
// ============================================================================
// Module   : comparador
// Brief    : Two-bit magnitude comparator; gt = (x > y), lt = (x < y).
// Revision : 1.0 - initial release
// ============================================================================
module comparador (
    input  wire logic [1:0] x,
    input  wire logic [1:0] y,
    output logic            gt,
    output logic            lt
);
    assign gt = (x > y);
    assign lt = (x < y);
endmodule

// ============================================================================
// Module   : elevator_controller
// Brief    : Four-floor elevator controller. Latches calls, picks direction
//            with a keep-direction (SCAN) policy, times floor travel and door
//            dwell, and drives Moore motor/door outputs.
// Revision : 1.0 - initial release
// ============================================================================
module elevator_controller #(
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    elevator_controller_if.slave  bus
);
    // One counter serves both travel and door timing; size it for the longer.
    localparam int CNT_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] c_travel_last = CNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_door_last   = CNT_W'(DOOR_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_up   = 2'd1;
    localparam logic [1:0] c_st_down = 2'd2;
    localparam logic [1:0] c_st_door = 2'd3;

    logic [1:0]       state_q,   state_d;
    logic [1:0]       floor_q,   floor_d;
    logic             dir_q,     dir_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [3:0]       pending_q, pending_d;

    logic [3:0] w_above;
    logic [3:0] w_below;
    logic       w_up_req;
    logic       w_down_req;
    logic [1:0] w_floor_up;
    logic [1:0] w_floor_dn;
    logic [3:0] w_floor_onehot;
    logic [3:0] w_call_eff;
    logic [3:0] w_clear;

    // Classify every floor index as above/below the car.
    for (genvar i = 0; i < 4; i++) begin : g_cmp
        comparador u_cmp (
            .x  (2'(i)),
            .y  (floor_q),
            .gt (w_above[i]),
            .lt (w_below[i])
        );
    end

    assign w_up_req       = |(pending_q & w_above);
    assign w_down_req     = |(pending_q & w_below);
    assign w_floor_up     = floor_q + 2'd1;
    assign w_floor_dn     = floor_q - 2'd1;
    assign w_floor_onehot = 4'b0001 << floor_q;

    // Next-state, position, direction, timer and call-latch logic.
    always_comb begin
        state_d = state_q;
        floor_d = floor_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        w_clear = 4'b0000;
        // A current-floor press with the door open only extends the dwell.
        w_call_eff = (state_q == c_st_door) ? (bus.call_req & ~w_floor_onehot)
                                            : bus.call_req;
        case (state_q)
            c_st_idle: begin
                cnt_d = '0;
                if (pending_q[floor_q]) begin
                    state_d = c_st_door;
                    w_clear = w_floor_onehot;
                end else if (dir_q && w_up_req) begin
                    state_d = c_st_up;
                end else if (w_down_req) begin
                    state_d = c_st_down;
                    dir_d   = 1'b0;
                end else if (w_up_req) begin
                    state_d = c_st_up;
                    dir_d   = 1'b1;
                end
            end
            c_st_up: begin
                if (cnt_q == c_travel_last) begin
                    floor_d = w_floor_up;
                    cnt_d   = '0;
                    if (pending_q[w_floor_up]) begin
                        state_d = c_st_door;
                        w_clear = 4'b0001 << w_floor_up;
                    end else if (w_floor_up == 2'd3) begin
                        // Defensive: never try to travel beyond the top floor.
                        state_d = c_st_idle;
                    end
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end
            c_st_down: begin
                if (cnt_q == c_travel_last) begin
                    floor_d = w_floor_dn;
                    cnt_d   = '0;
                    if (pending_q[w_floor_dn]) begin
                        state_d = c_st_door;
                        w_clear = 4'b0001 << w_floor_dn;
                    end else if (w_floor_dn == 2'd0) begin
                        // Defensive: never try to travel below the ground floor.
                        state_d = c_st_idle;
                    end
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end
            c_st_door: begin
                if (bus.call_req[floor_q]) begin
                    cnt_d = '0;
                end else if (cnt_q == c_door_last) begin
                    state_d = c_st_idle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end
            default: begin
                state_d = c_st_idle;
                cnt_d   = '0;
            end
        endcase
        pending_d = (pending_q | w_call_eff) & ~w_clear;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= c_st_idle;
            floor_q   <= 2'd0;
            dir_q     <= 1'b1;
            cnt_q     <= '0;
            pending_q <= 4'b0000;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            dir_q     <= dir_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    assign bus.current_floor = floor_q;
    assign bus.motor_up      = (state_q == c_st_up);
    assign bus.motor_down    = (state_q == c_st_down);
    assign bus.door_open     = (state_q == c_st_door);
    assign bus.pending       = pending_q;
endmodule
`default_nettype wire

// File: tb/tb_elevator_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_elevator_controller
// Brief    : Self-checking bench: directed scenarios plus random calls,
//            compared every cycle against a behavioural elevator model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_elevator_controller;
    localparam int TRAVEL = 4;
    localparam int DOOR   = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    elevator_controller_if bus ();

    elevator_controller #(
        .TRAVEL_CYCLES (TRAVEL),
        .DOOR_CYCLES   (DOOR)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural model: what the car is doing and how long it has left.
    typedef enum int {M_IDLE, M_UP, M_DOWN, M_DOOR} act_t;
    act_t     m_act   = M_IDLE;
    int       m_floor = 0;
    bit       m_dir   = 1'b1;
    bit [3:0] m_pend  = 4'b0000;
    int       m_rem   = 0;

    int checks = 0;
    int errors = 0;

    int  motor_cycles = 0;
    int  door_cycles  = 0;
    int  stops_code   = 0;   // door-open floors as decimal digits (floor+1)
    bit  prev_door    = 1'b0;

    task automatic model_step(input logic [3:0] c, input logic r);
        bit [3:0] p_new;
        bit       up, dn;
        int       nf;
        if (!r) begin
            m_act = M_IDLE; m_floor = 0; m_dir = 1'b1; m_pend = 4'b0000; m_rem = 0;
            return;
        end
        p_new = m_pend;
        for (int i = 0; i < 4; i++)
            if (c[i] && !(m_act == M_DOOR && i == m_floor)) p_new[i] = 1'b1;
        case (m_act)
            M_IDLE: begin
                up = 1'b0; dn = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    if (m_pend[i] && i > m_floor) up = 1'b1;
                    if (m_pend[i] && i < m_floor) dn = 1'b1;
                end
                if (m_pend[m_floor]) begin
                    m_act = M_DOOR; m_rem = DOOR; p_new[m_floor] = 1'b0;
                end else if (m_dir && up) begin
                    m_act = M_UP; m_rem = TRAVEL;
                end else if (dn) begin
                    m_act = M_DOWN; m_rem = TRAVEL; m_dir = 1'b0;
                end else if (up) begin
                    m_act = M_UP; m_rem = TRAVEL; m_dir = 1'b1;
                end
            end
            M_UP, M_DOWN: begin
                m_rem--;
                if (m_rem == 0) begin
                    nf      = (m_act == M_UP) ? m_floor + 1 : m_floor - 1;
                    m_floor = nf;
                    m_rem   = TRAVEL;
                    if (m_pend[nf]) begin
                        m_act = M_DOOR; m_rem = DOOR; p_new[nf] = 1'b0;
                    end else if (nf == 0 || nf == 3) begin
                        m_act = M_IDLE;
                    end
                end
            end
            M_DOOR: begin
                if (c[m_floor]) begin
                    m_rem = DOOR;
                end else begin
                    m_rem--;
                    if (m_rem == 0) m_act = M_IDLE;
                end
            end
            default: m_act = M_IDLE;
        endcase
        m_pend = p_new;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, update model at the edge, compare mid-cycle.
    task automatic cycle(input logic [3:0] c, input logic r);
        bus.call_req = c;
        rst_n        = r;
        @(posedge clk);
        model_step(c, r);
        @(negedge clk);
        chk("current_floor", 32'(bus.current_floor), 32'(m_floor));
        chk("motor_up",      32'(bus.motor_up),      32'(m_act == M_UP));
        chk("motor_down",    32'(bus.motor_down),    32'(m_act == M_DOWN));
        chk("door_open",     32'(bus.door_open),     32'(m_act == M_DOOR));
        chk("pending",       32'(bus.pending),       32'(m_pend));
        if (bus.motor_up || bus.motor_down) motor_cycles++;
        if (bus.door_open) door_cycles++;
        if (bus.door_open && !prev_door) stops_code = stops_code * 10 + int'(bus.current_floor) + 1;
        prev_door = bus.door_open;
    endtask

    task automatic clear_stats();
        motor_cycles = 0;
        door_cycles  = 0;
        stops_code   = 0;
    endtask

    initial begin
        logic [3:0] c;
        logic       r;
        bus.call_req = 4'b0000;

        // Reset with all call buttons held.
        repeat (3) cycle(4'b1111, 1'b0);
        chk("reset_pending", 32'(bus.pending), 32'd0);
        chk("reset_floor",   32'(bus.current_floor), 32'd0);

        // Single trip 0 -> 3.
        clear_stats();
        cycle(4'b1000, 1'b1);
        repeat (20) cycle(4'b0000, 1'b1);
        chk("trip_motor_cycles", 32'(motor_cycles), 32'd12);
        chk("trip_door_cycles",  32'(door_cycles),  32'd3);
        chk("trip_stops",        32'(stops_code),   32'd4);
        chk("trip_pending",      32'(bus.pending),  32'd0);

        // Call for the current floor while idle at floor 0.
        cycle(4'b0000, 1'b0);
        clear_stats();
        cycle(4'b0001, 1'b1);
        chk("cur_door_not_yet", 32'(bus.door_open), 32'd0);
        cycle(4'b0000, 1'b1);
        chk("cur_door_2cyc", 32'(bus.door_open), 32'd1);
        repeat (6) cycle(4'b0000, 1'b1);
        chk("cur_no_motor",    32'(motor_cycles), 32'd0);
        chk("cur_door_cycles", 32'(door_cycles),  32'd3);

        // SCAN order from floor 1 heading up: serve 3 then 0.
        cycle(4'b0000, 1'b0);
        cycle(4'b0010, 1'b1);
        repeat (12) cycle(4'b0000, 1'b1);
        chk("scan_start_floor", 32'(bus.current_floor), 32'd1);
        clear_stats();
        cycle(4'b1001, 1'b1);
        repeat (50) cycle(4'b0000, 1'b1);
        chk("scan_order", 32'(stops_code), 32'd41);

        // Intermediate stop at 2 on the way to 3.
        cycle(4'b0000, 1'b0);
        clear_stats();
        cycle(4'b1000, 1'b1);
        cycle(4'b0000, 1'b1);
        cycle(4'b0100, 1'b1);
        repeat (30) cycle(4'b0000, 1'b1);
        chk("intermediate_order", 32'(stops_code), 32'd34);

        // Door extend at floor 3.
        clear_stats();
        cycle(4'b1000, 1'b1);
        cycle(4'b0000, 1'b1);
        cycle(4'b1000, 1'b1);
        chk("extend_no_latch", 32'(bus.pending[3]), 32'd0);
        repeat (8) cycle(4'b0000, 1'b1);
        chk("extend_door_cycles", 32'(door_cycles), 32'd4);

        // Reset in the middle of an upward move.
        cycle(4'b0000, 1'b0);
        cycle(4'b1000, 1'b1);
        repeat (6) cycle(4'b0000, 1'b1);
        chk("pre_reset_moving", 32'(bus.motor_up), 32'd1);
        cycle(4'b0000, 1'b0);
        chk("midmove_motor", 32'(bus.motor_up),      32'd0);
        chk("midmove_floor", 32'(bus.current_floor), 32'd0);

        // Random calls with occasional resets.
        repeat (1500) begin
            c = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
            r = ($urandom_range(0, 299) != 0);
            cycle(c, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
